// File: rtl/cpu_trace_monitor_pkg.sv
// Shared types for the retire-trace monitor: FSM states and entry layout.
package cpu_trace_monitor_pkg;

    typedef enum logic [1:0] {
        ARMED   = 2'd0,
        RUN     = 2'd1,
        HALTED  = 2'd2,
        TIMEOUT = 2'd3
    } state_e;

    localparam int INST_W = 32;
    localparam int RD_W   = 5;

    // Entry packing, LSB first: rd data, rd index, instruction word, pc.
    function automatic int entry_w(input int xlen);
        return 2 * xlen + INST_W + RD_W;
    endfunction

endpackage

// File: rtl/cpu_trace_monitor_trace_ram.sv
// Trace storage: one synchronous write port, one registered read port.
module cpu_trace_monitor_trace_ram #(
    parameter int W     = 101,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/cpu_trace_monitor.sv
// Retire-trace recorder and halt/stall watchdog sitting beside the core.
module cpu_trace_monitor
    import cpu_trace_monitor_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16,
    parameter int CYC_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     commit_valid,
    input  logic [XLEN-1:0]          commit_pc,
    input  logic [INST_W-1:0]        commit_inst,
    input  logic [RD_W-1:0]          commit_rd,
    input  logic                     commit_rd_we,
    input  logic [XLEN-1:0]          commit_rd_data,
    input  logic                     cpu_halt,
    input  logic [CYC_W-1:0]         timeout_limit,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [XLEN-1:0]          rd_pc,
    output logic [INST_W-1:0]        rd_inst,
    output logic [RD_W-1:0]          rd_rd,
    output logic [XLEN-1:0]          rd_data,
    output logic [$clog2(DEPTH):0]   entries,
    output logic [CYC_W-1:0]         cycle_count,
    output logic [CYC_W-1:0]         retired_count,
    output logic                     done,
    output logic                     timeout
);

    localparam int AW      = $clog2(DEPTH);
    localparam int EW      = entry_w(XLEN);
    localparam int RD_LO   = XLEN;
    localparam int INST_LO = XLEN + RD_W;
    localparam int PC_LO   = XLEN + RD_W + INST_W;

    state_e          state;
    logic [AW-1:0]   wptr;
    logic [CYC_W-1:0] idle_cnt;
    logic [CYC_W-1:0] idle_nxt;
    logic            rd_ok;
    logic            live;
    logic            rec;
    logic            start;
    logic            in_run;
    logic            to_hit;
    logic [AW-1:0]   phys;
    logic [EW-1:0]   wdata;
    logic [EW-1:0]   rdata;

    assign live   = (state == ARMED) || (state == RUN);
    assign rec    = commit_valid && live;
    assign start  = (state == ARMED) && (commit_valid || cpu_halt);
    assign in_run = (state == RUN) || start;
    assign phys   = wptr - entries[AW-1:0] + rd_idx;

    assign wdata = {commit_pc, commit_inst,
                    commit_rd_we ? commit_rd : '0,
                    commit_rd_data};

    always_comb begin
        idle_nxt = idle_cnt;
        if (commit_valid)
            idle_nxt = '0;
        else if (state == RUN && idle_cnt != '1)
            idle_nxt = idle_cnt + CYC_W'(1);
    end

    // Fires on the cycle the idle count reaches the limit; halt has priority.
    assign to_hit = (state == RUN) && !cpu_halt &&
                    (timeout_limit != '0) && (idle_nxt == timeout_limit);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ARMED;
            wptr          <= '0;
            entries       <= '0;
            idle_cnt      <= '0;
            cycle_count   <= '0;
            retired_count <= '0;
            rd_ok         <= 1'b0;
        end else begin
            unique case (state)
                ARMED: if (commit_valid || cpu_halt) state <= RUN;
                RUN: begin
                    if (cpu_halt)    state <= HALTED;
                    else if (to_hit) state <= TIMEOUT;
                end
                default: ;
            endcase
            if (live)
                idle_cnt <= idle_nxt;
            if (in_run && cycle_count != '1)
                cycle_count <= cycle_count + CYC_W'(1);
            if (rec) begin
                wptr <= wptr + AW'(1);
                if (entries != (AW+1)'(DEPTH))
                    entries <= entries + (AW+1)'(1);
                if (retired_count != '1)
                    retired_count <= retired_count + CYC_W'(1);
            end
            rd_ok <= {1'b0, rd_idx} < entries;
        end
    end

    assign done    = (state == HALTED) || (state == TIMEOUT);
    assign timeout = (state == TIMEOUT);

    cpu_trace_monitor_trace_ram #(
        .W     (EW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (rec),
        .waddr (wptr),
        .wdata (wdata),
        .raddr (phys),
        .rdata (rdata)
    );

    assign rd_pc   = rd_ok ? rdata[PC_LO +: XLEN]     : '0;
    assign rd_inst = rd_ok ? rdata[INST_LO +: INST_W] : '0;
    assign rd_rd   = rd_ok ? rdata[RD_LO +: RD_W]     : '0;
    assign rd_data = rd_ok ? rdata[0 +: XLEN]         : '0;

endmodule

// File: tb/tb_cpu_trace_monitor.sv
// Self-checking bench for cpu_trace_monitor with a read-back scoreboard.
module tb_cpu_trace_monitor;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    logic        clk;
    logic        rst;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic [31:0] commit_inst;
    logic [4:0]  commit_rd;
    logic        commit_rd_we;
    logic [31:0] commit_rd_data;
    logic        cpu_halt;
    logic [31:0] timeout_limit;
    logic [3:0]  rd_idx;
    logic [31:0] rd_pc;
    logic [31:0] rd_inst;
    logic [4:0]  rd_rd;
    logic [31:0] rd_data;
    logic [4:0]  entries;
    logic [31:0] cycle_count;
    logic [31:0] retired_count;
    logic        done;
    logic        timeout;

    int   n_chk;
    int   n_err;
    ent_t hist[$];
    ent_t sb[$];
    bit   m_live;

    cpu_trace_monitor dut (
        .clk            (clk),
        .rst            (rst),
        .commit_valid   (commit_valid),
        .commit_pc      (commit_pc),
        .commit_inst    (commit_inst),
        .commit_rd      (commit_rd),
        .commit_rd_we   (commit_rd_we),
        .commit_rd_data (commit_rd_data),
        .cpu_halt       (cpu_halt),
        .timeout_limit  (timeout_limit),
        .rd_idx         (rd_idx),
        .rd_pc          (rd_pc),
        .rd_inst        (rd_inst),
        .rd_rd          (rd_rd),
        .rd_data        (rd_data),
        .entries        (entries),
        .cycle_count    (cycle_count),
        .retired_count  (retired_count),
        .done           (done),
        .timeout        (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input logic [31:0] lim);
        rst = 1'b0;
        commit_valid = 1'b0;
        cpu_halt = 1'b0;
        rd_idx = '0;
        timeout_limit = lim;
        hist.delete();
        m_live = 1'b1;
        step(1);
        rst = 1'b1;
    endtask

    task automatic commit(input logic [31:0] pc, input logic [31:0] inst,
                          input logic [4:0] rd, input logic we,
                          input logic [31:0] d, input logic halt);
        ent_t e;
        commit_valid = 1'b1;
        commit_pc = pc;
        commit_inst = inst;
        commit_rd = rd;
        commit_rd_we = we;
        commit_rd_data = d;
        cpu_halt = halt;
        if (m_live) begin
            e.pc = pc;
            e.inst = inst;
            e.rd = we ? rd : 5'd0;
            e.data = d;
            hist.push_back(e);
            if (hist.size() > 16) void'(hist.pop_front());
            if (halt) m_live = 1'b0;
        end
        step(1);
        commit_valid = 1'b0;
        cpu_halt = 1'b0;
    endtask

    task automatic rd_chk(input int idx);
        ent_t e;
        rd_idx = 4'(idx);
        e = (idx < hist.size()) ? hist[idx] : '0;
        sb.push_back(e);
        step(1);
        e = sb.pop_front();
        chk($sformatf("rd_pc[%0d]", idx), 64'(rd_pc), 64'(e.pc));
        chk($sformatf("rd_inst[%0d]", idx), 64'(rd_inst), 64'(e.inst));
        chk($sformatf("rd_rd[%0d]", idx), 64'(rd_rd), 64'(e.rd));
        chk($sformatf("rd_data[%0d]", idx), 64'(rd_data), 64'(e.data));
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst = 1'b0;
        commit_valid = 1'b0;
        commit_pc = '0;
        commit_inst = '0;
        commit_rd = '0;
        commit_rd_we = 1'b0;
        commit_rd_data = '0;
        cpu_halt = 1'b0;
        timeout_limit = '0;
        rd_idx = '0;
        #2;
        chk("rst_entries", 64'(entries), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_rd_pc", 64'(rd_pc), 64'd0);

        // three commits then halt
        do_reset(32'd0);
        chk("rst_cycle", 64'(cycle_count), 64'd0);
        chk("rst_retired", 64'(retired_count), 64'd0);
        chk("rst_timeout", 64'(timeout), 64'd0);
        commit(32'h0, 32'h13, 5'd10, 1'b1, 32'h11, 1'b0);
        commit(32'h4, 32'h93, 5'd10, 1'b1, 32'h22, 1'b0);
        commit(32'h8, 32'h113, 5'd10, 1'b1, 32'h33, 1'b0);
        cpu_halt = 1'b1;
        m_live = 1'b0;
        step(1);
        cpu_halt = 1'b0;
        chk("t1_done", 64'(done), 64'd1);
        chk("t1_timeout", 64'(timeout), 64'd0);
        chk("t1_entries", 64'(entries), 64'd3);
        chk("t1_retired", 64'(retired_count), 64'd3);
        chk("t1_cycle", 64'(cycle_count), 64'd4);
        rd_chk(2);
        rd_chk(0);
        commit(32'hC, 32'h13, 5'd1, 1'b1, 32'h44, 1'b0);
        chk("t1_frozen", 64'(retired_count), 64'd3);
        rd_chk(7);

        // wrap-around past DEPTH
        do_reset(32'd0);
        for (int i = 0; i < 20; i++)
            commit(32'(4 * i), 32'h13 + 32'(i), 5'(i), i[0], 32'(i * 256), 1'b0);
        chk("t2_entries", 64'(entries), 64'd16);
        chk("t2_retired", 64'(retired_count), 64'd20);
        rd_chk(0);
        chk("t2_oldest", 64'(rd_pc), 64'h10);
        rd_chk(15);
        chk("t2_newest", 64'(rd_pc), 64'h4C);
        for (int k = 0; k < 4; k++)
            rd_chk(int'($urandom_range(1, 14)));

        // watchdog
        do_reset(32'd5);
        commit(32'h100, 32'h13, 5'd2, 1'b1, 32'h1, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            step(1);
            chk($sformatf("t3_to_k%0d", k), 64'(timeout), 64'(k == 5));
        end
        m_live = 1'b0;
        chk("t3_done", 64'(done), 64'd1);
        commit(32'h104, 32'h13, 5'd2, 1'b1, 32'h2, 1'b0);
        commit(32'h108, 32'h13, 5'd2, 1'b1, 32'h3, 1'b0);
        chk("t3_retired", 64'(retired_count), 64'd1);
        rd_chk(0);

        // commit and halt together
        do_reset(32'd0);
        commit(32'h20, 32'h13, 5'd3, 1'b1, 32'hAA, 1'b0);
        commit(32'h40, 32'h73, 5'd4, 1'b0, 32'hBB, 1'b1);
        chk("t4_done", 64'(done), 64'd1);
        chk("t4_timeout", 64'(timeout), 64'd0);
        chk("t4_entries", 64'(entries), 64'd2);
        rd_chk(1);
        chk("t4_newest", 64'(rd_pc), 64'h40);

        // halt on the cycle the watchdog would fire
        do_reset(32'd3);
        commit(32'h200, 32'h13, 5'd5, 1'b1, 32'h5, 1'b0);
        step(2);
        cpu_halt = 1'b1;
        step(1);
        cpu_halt = 1'b0;
        chk("t5_done", 64'(done), 64'd1);
        chk("t5_timeout", 64'(timeout), 64'd0);

        // asynchronous reset mid-run
        do_reset(32'd0);
        commit(32'h300, 32'h13, 5'd6, 1'b1, 32'h6, 1'b0);
        commit(32'h304, 32'h13, 5'd6, 1'b1, 32'h7, 1'b0);
        commit(32'h308, 32'h13, 5'd6, 1'b1, 32'h8, 1'b0);
        chk("t5_pre_pc", 64'(rd_pc), 64'h300);
        rst = 1'b0;
        #1;
        chk("t5_ar_entries", 64'(entries), 64'd0);
        chk("t5_ar_retired", 64'(retired_count), 64'd0);
        chk("t5_ar_cycle", 64'(cycle_count), 64'd0);
        chk("t5_ar_rd_pc", 64'(rd_pc), 64'd0);
        chk("t5_ar_done", 64'(done), 64'd0);

        // watchdog disabled
        do_reset(32'd0);
        commit(32'h400, 32'h13, 5'd7, 1'b1, 32'h9, 1'b0);
        step(1000);
        chk("t6_timeout", 64'(timeout), 64'd0);
        chk("t6_done", 64'(done), 64'd0);
        chk("t6_cycle", 64'(cycle_count), 64'd1001);
        rd_chk(0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
